apa_cmd_monitor: RTL



---
 rtl/apa_cmd_monitor.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/apa_cmd_monitor.sv
// Passive monitor for the APA ACT->PRE->ACT->PRE sequence on one bank of the 4-slot PHY bundle.
// Optional result histograms are enabled by defining APA_MON_HIST_EN.
`ifndef BANK_SZ
`define BANK_SZ 3
`endif
`ifndef ROW_SZ
`define ROW_SZ 16
`endif
`ifndef DEC_DDR_CMD_SZ
`define DEC_DDR_CMD_SZ 3
`endif
`ifndef DDR_NOP
`define DDR_NOP 3'd0
`endif
`ifndef DDR_ACT
`define DDR_ACT 3'd1
`endif
`ifndef DDR_PRE
`define DDR_PRE 3'd2
`endif
`ifndef DDR_RD
`define DDR_RD 3'd3
`endif

module apa_cmd_monitor #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arm,
    input  logic [`BANK_SZ-1:0]            arm_bank,
    input  logic [`DEC_DDR_CMD_SZ*4-1:0]   phy_cmd,
    input  logic [`ROW_SZ*4-1:0]           phy_row,
    input  logic [`BANK_SZ*4-1:0]          phy_bank,
    output logic                           busy,
    output logic                           res_valid,
    output logic [1:0]                     res_err,
    output logic [7:0]                     res_t1,
    output logic [7:0]                     res_t2,
    output logic [7:0]                     res_tail,
    output logic [`ROW_SZ-1:0]             res_src_row,
    output logic [`ROW_SZ-1:0]             res_dst_row,
    output logic [15:0]                    hist_ok_cnt,
    output logic [15:0]                    hist_err_cnt
);

    localparam int CW = `DEC_DDR_CMD_SZ;
    localparam int RW = `ROW_SZ;
    localparam int BW = `BANK_SZ;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {IDLE, W_ACT1, W_PRE1, W_ACT2, W_PRE2} state_t;

    state_t          state, nxt_state;
    logic [BW-1:0]   bank_q;
    logic [15:0]     cyc;
    logic [TW-1:0]   tcnt;
    logic [17:0]     ts_last, nxt_ts;
    logic [7:0]      t1_q, t2_q, nxt_t1, nxt_t2, nxt_tail;
    logic [RW-1:0]   src_q, dst_q, nxt_src, nxt_dst;
    logic            fin, accepted;
    logic [1:0]      fin_err;
    logic [CW-1:0]   slot_cmd;
    logic [RW-1:0]   slot_row;
    logic [17:0]     slot_ts;

    function automatic logic [7:0] sat_diff(input logic [17:0] from_ts, input logic [17:0] to_ts);
        logic [17:0] d;
        d = to_ts - from_ts;
        return (d > 18'd255) ? 8'hFF : d[7:0];
    endfunction

    assign busy = (state != IDLE);

    // Walk the four slots in order; the first abort or the final PRE freezes the rest of the bundle.
    always_comb begin
        nxt_state = state;
        nxt_ts    = ts_last;
        nxt_t1    = t1_q;
        nxt_t2    = t2_q;
        nxt_tail  = 8'd0;
        nxt_src   = src_q;
        nxt_dst   = dst_q;
        fin       = 1'b0;
        fin_err   = 2'd0;
        accepted  = 1'b0;
        slot_cmd  = '0;
        slot_row  = '0;
        slot_ts   = '0;
        for (int s = 0; s < 4; s++) begin
            slot_cmd = phy_cmd[CW*s +: CW];
            slot_row = phy_row[RW*s +: RW];
            slot_ts  = {cyc, 2'(s)};
            if (!fin && state != IDLE && phy_bank[BW*s +: BW] == bank_q && slot_cmd != `DDR_NOP) begin
                case (nxt_state)
                    W_ACT1: begin
                        if (slot_cmd == `DDR_ACT) begin
                            nxt_src   = slot_row;
                            nxt_ts    = slot_ts;
                            nxt_state = W_PRE1;
                            accepted  = 1'b1;
                        end else if (slot_cmd != `DDR_PRE) begin
                            fin     = 1'b1;
                            fin_err = 2'd1;
                        end
                    end
                    W_PRE1: begin
                        if (slot_cmd == `DDR_PRE) begin
                            nxt_t1    = sat_diff(nxt_ts, slot_ts);
                            nxt_ts    = slot_ts;
                            nxt_state = W_ACT2;
                            accepted  = 1'b1;
                        end else begin
                            fin     = 1'b1;
                            fin_err = (slot_cmd == `DDR_ACT) ? 2'd2 : 2'd1;
                        end
                    end
                    W_ACT2: begin
                        if (slot_cmd == `DDR_ACT) begin
                            nxt_t2    = sat_diff(nxt_ts, slot_ts);
                            nxt_dst   = slot_row;
                            nxt_ts    = slot_ts;
                            nxt_state = W_PRE2;
                            accepted  = 1'b1;
                        end else begin
                            fin     = 1'b1;
                            fin_err = (slot_cmd == `DDR_PRE) ? 2'd2 : 2'd1;
                        end
                    end
                    W_PRE2: begin
                        if (slot_cmd == `DDR_PRE) begin
                            nxt_tail = sat_diff(nxt_ts, slot_ts);
                            accepted = 1'b1;
                            fin      = 1'b1;
                        end else begin
                            fin     = 1'b1;
                            fin_err = (slot_cmd == `DDR_ACT) ? 2'd2 : 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (!fin && state != IDLE && !accepted && tcnt == TW'(TIMEOUT_CYC - 1)) begin
            fin     = 1'b1;
            fin_err = 2'd3;
        end
        if (fin) nxt_state = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bank_q      <= '0;
            cyc         <= '0;
            tcnt        <= '0;
            ts_last     <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            res_valid   <= 1'b0;
            res_err     <= '0;
            res_t1      <= '0;
            res_t2      <= '0;
            res_tail    <= '0;
            res_src_row <= '0;
            res_dst_row <= '0;
        end else begin
            res_valid <= 1'b0;
            if (state == IDLE) begin
                if (arm) begin
                    state   <= W_ACT1;
                    bank_q  <= arm_bank;
                    cyc     <= '0;
                    tcnt    <= '0;
                    ts_last <= '0;
                    t1_q    <= '0;
                    t2_q    <= '0;
                    src_q   <= '0;
                    dst_q   <= '0;
                end
            end else begin
                state   <= nxt_state;
                cyc     <= (cyc == 16'hFFFF) ? cyc : cyc + 16'd1;
                tcnt    <= accepted ? '0 : tcnt + TW'(1);
                ts_last <= nxt_ts;
                t1_q    <= nxt_t1;
                t2_q    <= nxt_t2;
                src_q   <= nxt_src;
                dst_q   <= nxt_dst;
                if (fin) begin
                    res_valid   <= 1'b1;
                    res_err     <= fin_err;
                    res_t1      <= nxt_t1;
                    res_t2      <= nxt_t2;
                    res_tail    <= nxt_tail;
                    res_src_row <= nxt_src;
                    res_dst_row <= nxt_dst;
                end
            end
        end
    end

`ifdef APA_MON_HIST_EN
    logic [15:0] hist_ok_q, hist_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_ok_q  <= '0;
            hist_err_q <= '0;
        end else if (fin) begin
            if (fin_err == 2'd0) begin
                if (hist_ok_q != 16'hFFFF) hist_ok_q <= hist_ok_q + 16'd1;
            end else begin
                if (hist_err_q != 16'hFFFF) hist_err_q <= hist_err_q + 16'd1;
            end
        end
    end

    assign hist_ok_cnt  = hist_ok_q;
    assign hist_err_cnt = hist_err_q;
`else
    assign hist_ok_cnt  = 16'd0;
    assign hist_err_cnt = 16'd0;
`endif

endmodule
